dcache: RTL and testbench
=========================

# dcache

Blocking, direct-mapped, write-through data cache directly downstream of the AGU. It accepts one load or store per cycle on the AGU's dcache port and answers loads one cycle later. Misses and busy cycles are refused with a nack, and the AGU replays them. It fetches misses from and writes stores through to a word-addressed backing memory over a req/ack handshake.

## Interface
Parameters:
- WIDTH_MEM, 4: word-address width.
- WIDTH_IDX, 2: index bits; 2^WIDTH_IDX lines of one word each; must be < WIDTH_MEM.
- WIDTH_DATA, 32: data width.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_addr  in  WIDTH_MEM  request word address.
- i_data  in  WIDTH_DATA  store data.
- i_re  in  1  load request.
- i_we  in  1  store request; if i_re is also high, the request is a store.
- i_kill  in  1  squash this cycle's request.
- o_val  out  1  response valid, one cycle after the request.
- o_nack  out  1  request refused; the AGU must replay it.
- o_data  out  WIDTH_DATA  load data when o_val & ~o_nack and the request was a load; 0 otherwise.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write (1) or read (0).
- o_mem_addr  out  WIDTH_MEM  memory address.
- o_mem_data  out  WIDTH_DATA  memory write data.
- i_mem_data  in  WIDTH_DATA  read data, valid with i_mem_ack.
- i_mem_ack  in  1  completes the outstanding memory request.

## Operation
- Address split: index = i_addr[WIDTH_IDX-1:0]; tag = i_addr[WIDTH_MEM-1:WIDTH_IDX].
- Each line has a valid bit, a tag and a data word.
- FSM states:
  - IDLE
  - REFILL: read outstanding.
  - WRITE: write-through outstanding.
- A request exists when (i_re | i_we) & ~i_kill. A killed request leaves no state change, and its response has o_val=0.
- In IDLE:
  - Load hit: response o_val=1, o_nack=0, o_data=line data.
  - Load miss: response o_val=1, o_nack=1. Capture the address into the memory request registers, set o_mem_we=0, go to REFILL.
  - Store: the line is updated only on a tag hit (no write-allocate). Capture address and data, set o_mem_we=1, go to WRITE. Response o_val=1, o_nack=0.
- In REFILL or WRITE, every unkilled request gets o_val=1, o_nack=1 and causes no state change.
- REFILL, on i_mem_ack: write i_mem_data into the line at the captured index, set valid and the tag, go to IDLE.
- WRITE, on i_mem_ack: go to IDLE.
- Kill does not abort an outstanding memory transaction.

## Timing
- Reset values, all asynchronous:
  - state=IDLE; all valid bits 0.
  - o_val, o_nack, o_data, o_mem_req, o_mem_we, o_mem_addr, o_mem_data all 0.
- Response latency: a request at edge N gives a response registered at N and visible during cycle N+1.
- o_mem_req rises in the cycle after the miss or store is accepted. Address, data and we stay stable until i_mem_ack is sampled high. o_mem_req is 0 in the cycle after the ack.
- Ack latency is at least 1 cycle after o_mem_req rises, with no upper bound. i_mem_ack is ignored while o_mem_req=0.
- Ack cycle: the FSM is still REFILL/WRITE, so a request in that cycle is nacked. The first acceptable request comes in the cycle after the ack.
- A refilled line is visible to a load in the cycle after the ack.
- Back-to-back hits: one load per cycle, no bubbles.
- Reset mid-transaction: o_mem_req drops immediately, the transaction is abandoned and all lines are invalidated. Memory must tolerate the dropped request.

## Structure
- Package dcache_pkg holds:
  - state enum: IDLE, REFILL, WRITE.
  - a line struct: valid, tag, data.
- Sub-module dcache_array: tag/valid/data storage with one combinational read port and one write port. It has asynchronous clear of the valid bits only.
- The top level holds the FSM, the response registers and the memory request registers.

## Test plan
- Cold load: reset, load addr 4 → next cycle o_val=1, o_nack=1; then o_mem_req=1, we=0, addr=4. Ack 2 cycles later with 0x0000ffff; replay load 4 → o_data=0x0000ffff, o_nack=0.
- Store hit: line 4 valid, store addr 4 data 3 → o_nack=0; o_mem_req, we=1, addr=4, data=3. A load of 4 during WRITE is nacked. After the ack, load 4 returns 3 with no miss.
- Killed store: store addr 4 data 7 with i_kill=1 → o_val=0, no o_mem_req, and load 4 still returns 3.
- Conflict (WIDTH_IDX=2): load 1 fills 0xf; load 5 misses and refills; load 1 misses again. Hits on 2 and 3 issued on consecutive cycles return data on consecutive cycles.
- Reset mid-refill: assert i_rst_n=0 while o_mem_req=1 → o_mem_req=0 at once. After release, a load of a previously cached address misses.
- i_re & i_we together at addr 2 data 9 → treated as a store: memory write of 9, o_data=0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-through data cache: FSM states and
// the default cache line layout.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH_MEM  = 4;
  localparam int DEF_WIDTH_IDX  = 2;
  localparam int DEF_WIDTH_DATA = 32;

  // Line layout for the default geometry; the top builds the same shape from its own parameters.
  typedef struct packed {
    logic                                   valid;
    logic [DEF_WIDTH_MEM-DEF_WIDTH_IDX-1:0] tag;
    logic [DEF_WIDTH_DATA-1:0]              data;
  } line_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the dcache: one combinational read port, one write port.
// Only the valid bits are cleared by reset; tag and data are plain storage.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int  WIDTH_IDX = DEF_WIDTH_IDX,
  parameter type cline_t   = line_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IDX-1:0] rd_idx,
  output cline_t               rd_line,
  input  logic                 wr_en,
  input  logic [WIDTH_IDX-1:0] wr_idx,
  input  cline_t               wr_line
);

  localparam int LINES = 1 << WIDTH_IDX;

  logic   valid_reg [LINES];
  cline_t line_mem  [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) valid_reg[i] <= 1'b0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= wr_line.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_idx] <= wr_line;
  end

  // The valid field kept in line_mem is stale after a reset, so the flop copy overrides it.
  always_comb begin
    rd_line       = line_mem[rd_idx];
    rd_line.valid = valid_reg[rd_idx];
  end

endmodule

// File: rtl/dcache.sv
// Blocking direct-mapped write-through data cache. Loads answer one cycle
// later; misses and requests during a memory transaction are nacked.
module dcache
  import dcache_pkg::*;
#(
  parameter int WIDTH_MEM  = DEF_WIDTH_MEM,
  parameter int WIDTH_IDX  = DEF_WIDTH_IDX,
  parameter int WIDTH_DATA = DEF_WIDTH_DATA
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH_MEM-1:0]  i_addr,
  input  logic [WIDTH_DATA-1:0] i_data,
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic                  i_kill,
  output logic                  o_val,
  output logic                  o_nack,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [WIDTH_MEM-1:0]  o_mem_addr,
  output logic [WIDTH_DATA-1:0] o_mem_data,
  input  logic [WIDTH_DATA-1:0] i_mem_data,
  input  logic                  i_mem_ack
);

  localparam int WIDTH_TAG = WIDTH_MEM - WIDTH_IDX;

  typedef struct packed {
    logic                  valid;
    logic [WIDTH_TAG-1:0]  tag;
    logic [WIDTH_DATA-1:0] data;
  } cline_t;

  state_t               state;
  cline_t               rd_line;
  cline_t               wr_line;
  logic                 wr_en;
  logic [WIDTH_IDX-1:0] wr_idx;
  logic                 req;
  logic                 hit;
  logic                 mem_done;
  logic [WIDTH_IDX-1:0] idx;
  logic [WIDTH_TAG-1:0] tag;

  assign idx      = i_addr[WIDTH_IDX-1:0];
  assign tag      = i_addr[WIDTH_MEM-1:WIDTH_IDX];
  assign req      = (i_re | i_we) & ~i_kill;
  assign hit      = rd_line.valid && (rd_line.tag == tag);
  // An ack only counts while a request is actually on the bus.
  assign mem_done = o_mem_req & i_mem_ack;

  dcache_array #(
    .WIDTH_IDX (WIDTH_IDX),
    .cline_t   (cline_t)
  ) u_array (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .rd_idx  (idx),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_line (wr_line)
  );

  // Store hits update the line in place; refills install the fetched word at the captured address.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_line = '{valid: 1'b1, tag: tag, data: i_data};
    if (state == IDLE && req && i_we && hit) begin
      wr_en = 1'b1;
    end else if (state == REFILL && mem_done) begin
      wr_en        = 1'b1;
      wr_idx       = o_mem_addr[WIDTH_IDX-1:0];
      wr_line.tag  = o_mem_addr[WIDTH_MEM-1:WIDTH_IDX];
      wr_line.data = i_mem_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_val      <= 1'b0;
      o_nack     <= 1'b0;
      o_data     <= '0;
      o_mem_req  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      o_val  <= req;
      o_nack <= 1'b0;
      o_data <= '0;
      case (state)
        IDLE: begin
          if (req && i_we) begin
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b1;
            o_mem_addr <= i_addr;
            o_mem_data <= i_data;
            state      <= WRITE;
          end else if (req && hit) begin
            o_data <= rd_line.data;
          end else if (req) begin
            o_nack     <= 1'b1;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= i_addr;
            state      <= REFILL;
          end
        end
        REFILL, WRITE: begin
          o_nack <= req;
          if (mem_done) begin
            o_mem_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Randomized and directed bench for dcache against a cache/memory model that
// tracks only which tags are resident and what backing memory holds.
module tb_dcache;
  localparam int WM = 4;
  localparam int WI = 2;
  localparam int WD = 32;
  localparam int LINES = 1 << WI;
  localparam int WORDS = 1 << WM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [WM-1:0] addr;
  logic [WD-1:0] wdata;
  logic          re, we, kill;
  logic          val, nack;
  logic [WD-1:0] rdata;
  logic          mem_req, mem_we;
  logic [WM-1:0] mem_addr;
  logic [WD-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;

  dcache #(.WIDTH_MEM(WM), .WIDTH_IDX(WI), .WIDTH_DATA(WD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_data(wdata),
    .i_re(re), .i_we(we), .i_kill(kill),
    .o_val(val), .o_nack(nack), .o_data(rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_data(mem_wdata), .i_mem_data(mem_rdata), .i_mem_ack(mem_ack)
  );

  int checks = 0;
  int errors = 0;

  // Reference: backing memory, resident tags, and whether a memory transaction is outstanding.
  logic [WD-1:0]    mem   [WORDS];
  bit               m_valid [LINES];
  logic [WM-WI-1:0] m_tag [LINES];
  int               busy;  // 0 none, 1 read outstanding, 2 write outstanding
  logic             exp_val, exp_nack, exp_mem_req, exp_mem_we;
  logic [WD-1:0]    exp_data, exp_mem_data;
  logic [WM-1:0]    exp_mem_addr;

  bit cmp_en = 0;
  bit rand_ack = 0;
  int ack_delay = 2;
  int ack_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("o_val", 64'(val), 64'(exp_val));
      check("o_nack", 64'(nack), 64'(exp_nack));
      check("o_data", 64'(rdata), 64'(exp_data));
      check("o_mem_req", 64'(mem_req), 64'(exp_mem_req));
      check("o_mem_we", 64'(mem_we), 64'(exp_mem_we));
      check("o_mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
      if (exp_mem_req && exp_mem_we) check("o_mem_data", 64'(mem_wdata), 64'(exp_mem_data));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    busy = 0;
    exp_val = 0; exp_nack = 0; exp_data = '0;
    exp_mem_req = 0; exp_mem_we = 0; exp_mem_addr = '0; exp_mem_data = '0;
  endtask

  task automatic model_step();
    bit            req, hit, ack_eff;
    int            li;
    logic [WI-1:0] i_idx;
    i_idx   = addr[WI-1:0];
    req     = (re || we) && !kill;
    hit     = m_valid[i_idx] && (m_tag[i_idx] == addr[WM-1:WI]);
    ack_eff = exp_mem_req && mem_ack;
    exp_val = req;
    exp_data = '0;
    if (busy != 0) begin
      exp_nack = req;
      if (ack_eff) begin
        if (busy == 1) begin
          li = int'(exp_mem_addr[WI-1:0]);
          m_valid[li] = 1;
          m_tag[li]   = exp_mem_addr[WM-1:WI];
        end else begin
          mem[exp_mem_addr] = exp_mem_data;
        end
        busy = 0;
        exp_mem_req = 0;
      end
    end else begin
      exp_nack = 0;
      if (req && we) begin
        exp_mem_req = 1; exp_mem_we = 1; exp_mem_addr = addr; exp_mem_data = wdata;
        busy = 2;
      end else if (req && hit) begin
        // Write-through with no accepted load during a write: a hit must equal memory.
        exp_data = mem[addr];
      end else if (req) begin
        exp_nack = 1;
        exp_mem_req = 1; exp_mem_we = 0; exp_mem_addr = addr;
        busy = 1;
      end
    end
  endtask

  task automatic drive_mem();
    if (mem_req) begin
      if (ack_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        ack_cnt++;
      end
    end else begin
      // Acks while no request is pending must be ignored by the cache.
      mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      ack_cnt = 0;
      ack_delay = rand_ack ? $urandom_range(1, 4) : 2;
    end
  endtask

  task automatic step(bit r, bit w, bit k, logic [WM-1:0] a, logic [WD-1:0] d);
    re = r; we = w; kill = k; addr = a; wdata = d;
    drive_mem();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_mem();
    int n = 0;
    while (mem_req !== 1'b0 && n < 30) begin
      step(0, 0, 0, '0, '0);
      n++;
    end
    check("mem_timeout", 64'(n < 30), 64'd1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    mem_ack = 1'b0;
    re = 0; we = 0; kill = 0;
    #1 check("rst_mem_req", 64'(mem_req), 64'd0);
    model_reset();
    ack_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WM-1:0] ra;
    logic [WD-1:0] rd;
    int op;
    rst_n = 1'b0; re = 0; we = 0; kill = 0; addr = '0; wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[4] = 32'h0000ffff;
    mem[1] = 32'h0000000f;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_val", 64'(val), 64'd0);
    check("reset_nack", 64'(nack), 64'd0);
    check("reset_data", 64'(rdata), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    cmp_en = 1;

    // Cold load of 4
    step(1, 0, 0, 4'd4, '0);
    check("cold_val", 64'(val), 64'd1);
    check("cold_nack", 64'(nack), 64'd1);
    check("cold_mem_req", 64'(mem_req), 64'd1);
    check("cold_mem_we", 64'(mem_we), 64'd0);
    check("cold_mem_addr", 64'(mem_addr), 64'd4);
    wait_mem();
    step(1, 0, 0, 4'd4, '0);
    check("replay_nack", 64'(nack), 64'd0);
    check("replay_data", 64'(rdata), 64'h0000ffff);

    // Store hit, load during WRITE, then hit on new data
    step(0, 1, 0, 4'd4, 32'd3);
    check("st_nack", 64'(nack), 64'd0);
    check("st_mem_we", 64'(mem_we), 64'd1);
    check("st_mem_data", 64'(mem_wdata), 64'd3);
    step(1, 0, 0, 4'd4, '0);
    check("ld_in_write_nack", 64'(nack), 64'd1);
    wait_mem();
    step(1, 0, 0, 4'd4, '0);
    check("st_hit_data", 64'(rdata), 64'd3);
    check("st_hit_no_miss", 64'(mem_req), 64'd0);

    // Killed store
    step(0, 1, 1, 4'd4, 32'd7);
    check("kill_val", 64'(val), 64'd0);
    check("kill_mem_req", 64'(mem_req), 64'd0);
    step(1, 0, 0, 4'd4, '0);
    check("kill_data", 64'(rdata), 64'd3);

    // Conflict between 1 and 5 on index 1
    step(1, 0, 0, 4'd1, '0); wait_mem();
    step(1, 0, 0, 4'd1, '0);
    check("ld1_data", 64'(rdata), 64'h0000000f);
    step(1, 0, 0, 4'd5, '0);
    check("ld5_miss", 64'(nack), 64'd1);
    wait_mem();
    step(1, 0, 0, 4'd1, '0);
    check("ld1_conflict_miss", 64'(nack), 64'd1);
    wait_mem();
    step(1, 0, 0, 4'd2, '0); wait_mem();
    step(1, 0, 0, 4'd3, '0); wait_mem();
    step(1, 0, 0, 4'd2, '0);
    check("b2b_2_nack", 64'(nack), 64'd0);
    step(1, 0, 0, 4'd3, '0);
    check("b2b_3_nack", 64'(nack), 64'd0);

    // Load and store together is a store
    step(1, 1, 0, 4'd2, 32'd9);
    check("rewe_data", 64'(rdata), 64'd0);
    check("rewe_mem_we", 64'(mem_we), 64'd1);
    check("rewe_mem_data", 64'(mem_wdata), 64'd9);
    wait_mem();
    step(1, 0, 0, 4'd2, '0);
    check("rewe_readback", 64'(rdata), 64'd9);

    // Reset during a refill
    step(1, 0, 0, 4'd5, '0);
    check("pre_rst_mem_req", 64'(mem_req), 64'd1);
    async_reset();
    step(1, 0, 0, 4'd4, '0);
    check("post_rst_miss", 64'(nack), 64'd1);
    wait_mem();

    // Random traffic
    rand_ack = 1;
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 99);
      ra = WM'($urandom);
      rd = $urandom;
      if (op == 0) async_reset();
      else step(op < 60, (op >= 45) && (op < 80), $urandom_range(0, 99) < 10, ra, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
